ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Round-robin arbiter that shares one single-read-port RAM instance (1-cycle registered read, one write port) among up to 8 requesters (CPU, video fetch, DMA, debug). It grants at most one access per cycle and routes write data and addresses to the RAM. It returns read data to the winning requester with a per-requester valid strobe. A requester may lock the port for a bounded burst.

## Interface
- NUM_REQ, 4: number of requesters, legal 2..8
- ADDR_WIDTH, 16: RAM address width
- DATA_WIDTH, 8: RAM data width
- MAX_BURST, 16: maximum accepted transfers per locked tenure, legal 2..256

Ports:
- Clock  in  1  system clock, all logic on posedge
- Reset  in  1  synchronous, active-high
- iReq  in  NUM_REQ  per-requester access request
- iWrite  in  NUM_REQ  1 = write, 0 = read, per requester
- iLock  in  NUM_REQ  request a locked burst, per requester
- iAddr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester k occupies [k*ADDR_WIDTH +: ADDR_WIDTH]
- iWData  in  NUM_REQ*DATA_WIDTH  flattened write data, same packing as iAddr
- oGrant  out  NUM_REQ  one-hot or zero, combinational; a transfer is accepted when iReq[k] & oGrant[k]
- oRdValid  out  NUM_REQ  one-hot or zero, read data valid for requester k
- oRdData  out  DATA_WIDTH  read data, shared by all requesters
- oRamWriteEnable  out  1  to RAM write enable
- oRamReadAddress  out  ADDR_WIDTH  to RAM read address
- oRamWriteAddress  out  ADDR_WIDTH  to RAM write address
- oRamDataIn  out  DATA_WIDTH  to RAM write data
- iRamDataOut  in  DATA_WIDTH  from RAM, registered read data

## Operation
- State register has two states, ARB_IDLE and ARB_LOCKED. It also holds a priority pointer rPtr (log2 NUM_REQ bits), an owner index rOwner, a burst counter rBurst (8 bits), and a pending-read tag rRdTag (NUM_REQ bits, one-hot).
- ARB_IDLE: grant goes to the first k with iReq[k] set, searching rPtr, rPtr+1, … modulo NUM_REQ. After an accepted transfer, rPtr = winner+1 modulo NUM_REQ. If the winner also has iLock set: go to ARB_LOCKED, rOwner = winner, rBurst = 1. In the locked case rPtr is not updated yet.
- ARB_LOCKED: oGrant = one-hot(rOwner) whenever iReq[rOwner] is set, regardless of other requests.
  - Accepted transfer with iLock[rOwner] still set: rBurst increments.
  - The port is released to ARB_IDLE when either (a) iReq[rOwner] or iLock[rOwner] is low in a cycle, or (b) an accepted transfer brings rBurst to MAX_BURST.
  - On release, rPtr = rOwner+1. That transfer, if accepted, still completes.
  - In a release-by-drop cycle with no accepted transfer, oGrant = 0. Arbitration resumes the next cycle.
- RAM drive, combinational from the accepted requester:
  - Read and write addresses both equal that requester's iAddr slice. oRamDataIn equals its iWData slice.
  - oRamWriteEnable = accepted & iWrite[winner].
  - With no accepted transfer, oRamWriteEnable = 0 and the address/data outputs are don't-care. The implementation drives the rPtr requester's slice.
- Read return: an accepted read sets rRdTag = one-hot(winner) for one cycle, so oRdValid = rRdTag. oRdData = iRamDataOut, passed through unregistered.
- Accepted writes produce no oRdValid.
- Back-to-back reads from different requesters are allowed every cycle.

## Timing
- Grant is combinational, same cycle as request. Write commits at the accepting edge. Read data and oRdValid appear exactly 1 cycle after the accepting edge.
- Reset, in the cycle Reset is high:
  - oGrant = 0, oRamWriteEnable = 0.
  - At the edge: state = ARB_IDLE, rPtr = 0, rOwner = 0, rBurst = 0, rRdTag = 0, so oRdValid = 0 the following cycle.
  - A read accepted the cycle before Reset still has its oRdValid killed.
- Boundaries:
  - All requests low: no grant, pointer holds.
  - Single requester: granted every cycle.
  - Pointer at NUM_REQ-1 wraps to 0.
  - iLock without iReq is ignored.
  - With NUM_REQ not a power of two, pointer wrap uses compare-and-clear, not modulo by bit truncation.

## Structure
- Shared definitions header holds the ARB_IDLE/ARB_LOCKED encodings and the NUM_REQ/MAX_BURST defaults.
- Sub-module rr_priority_pick: combinational rotate-priority picker. Inputs are the request vector and the pointer. Outputs are a one-hot grant and a binary index. The arbiter FSM, counters and read-tag register wrap it.
- State and counter registers use the codebase's synchronous-reset flop primitives.

## Test plan
- Reset, then iReq=4'b1111 (all reads) for 8 cycles -> grants 0,1,2,3,0,1,2,3. Each oRdValid arrives 1 cycle later carrying the RAM contents preloaded at that requester's address.
- Requester 2 writes 0xA5 to 0x0010. The next cycle requester 0 reads 0x0010 -> oRdValid=4'b0001 with oRdData=0xA5 one cycle after the read grant.
- MAX_BURST=4: requester 1 holds iReq and iLock while requesters 0 and 3 also request -> exactly 4 consecutive grants to 1, then grant 3, then 0.
- Requester 3 locks, then drops iLock after 2 transfers -> release. The next grant is 0 (pointer 3+1 wraps).
- Reset asserted the cycle after an accepted read -> oRdValid stays 0. The first grant after reset goes to the lowest-index requester.
- NUM_REQ=3, only requester 2 requesting for 5 cycles -> granted every cycle; pointer wraps to 0 with no X and no out-of-range index.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: FSM encodings and parameter defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
// Contents: arb_state_e (ARB_IDLE / ARB_LOCKED), DEF_NUM_REQ, DEF_MAX_BURST, BURST_W.
package ram_port_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 16;
  // Burst counter width; MAX_BURST up to 256 never needs to be stored because
  // the release happens on the transfer that would reach it.
  localparam int BURST_W       = 8;

endpackage

// File: rtl/ram_port_arbiter_rr_priority_pick.sv
// Rotating-priority picker: first set request searching from ptr_i upward, modulo N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; a zero request vector yields a zero grant.
// Ports: req_i (N requests), ptr_i (search start), gnt_o (one-hot or zero), idx_o (binary winner).
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int cand;
      // Compare-and-subtract wrap so non-power-of-two N never truncates into range.
      cand = int'(ptr_i) + i;
      if (cand >= N) cand = cand - N;
      if (!found && (cand < N) && req_i[PW'(cand)]) begin
        found             = 1'b1;
        gnt_o[PW'(cand)]  = 1'b1;
        idx_o             = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM (1-cycle registered read, one write port) among NUM_REQ requesters.
// Latency: grant and RAM drive combinational; read data/oRdValid 1 cycle after the accepting edge.
// Backpressure: oGrant low stalls a requester; a locked owner holds the port up to MAX_BURST transfers.
// Ports: Clock/Reset (sync, active-high), per-requester iReq/iWrite/iLock/iAddr/iWData,
//        oGrant/oRdValid/oRdData back to requesters, oRam*/iRamDataOut to the RAM.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [NUM_REQ-1:0]            iReq,
  input  logic [NUM_REQ-1:0]            iWrite,
  input  logic [NUM_REQ-1:0]            iLock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] iAddr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] iWData,
  output logic [NUM_REQ-1:0]            oGrant,
  output logic [NUM_REQ-1:0]            oRdValid,
  output logic [DATA_WIDTH-1:0]         oRdData,
  output logic                          oRamWriteEnable,
  output logic [ADDR_WIDTH-1:0]         oRamReadAddress,
  output logic [ADDR_WIDTH-1:0]         oRamWriteAddress,
  output logic [DATA_WIDTH-1:0]         oRamDataIn,
  input  logic [DATA_WIDTH-1:0]         iRamDataOut
);

  localparam int PW = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [NUM_REQ-1:0] rd_tag_q, rd_tag_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [PW-1:0]      pick_idx;
  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      sel_idx;
  logic               accepted;

  function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] v);
    if (int'(v) == NUM_REQ - 1) return '0;
    return v + 1'b1;
  endfunction

  rr_priority_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req_i (iReq),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      burst_q  <= '0;
      rd_tag_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      burst_q  <= burst_d;
      rd_tag_q <= rd_tag_d;
    end
  end

  // Output logic: grant, accepted winner and RAM drive
  always_comb begin
    oGrant = '0;
    if (!Reset) begin
      if (state_q == ARB_IDLE) begin
        oGrant = pick_gnt;
      end else if (iReq[owner_q]) begin
        oGrant[owner_q] = 1'b1;
      end
    end
  end

  // Every grant bit is qualified by its request, so any grant is an accepted transfer.
  assign accepted = |oGrant;
  assign win_idx  = (state_q == ARB_LOCKED) ? owner_q : pick_idx;
  // With nothing accepted the RAM still sees a defined in-range slice.
  assign sel_idx  = accepted ? win_idx : ptr_q;

  assign oRamWriteEnable  = accepted & iWrite[win_idx];
  assign oRamReadAddress  = iAddr[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign oRamWriteAddress = iAddr[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign oRamDataIn       = iWData[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];

  // A read tagged just before reset is suppressed during the reset cycle too.
  assign oRdValid = Reset ? '0 : rd_tag_q;
  assign oRdData  = iRamDataOut;

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    burst_d  = burst_q;
    rd_tag_d = '0;

    if (accepted && !iWrite[win_idx]) rd_tag_d[win_idx] = 1'b1;

    case (state_q)
      ARB_IDLE: begin
        if (accepted) begin
          if (iLock[win_idx]) begin
            // Pointer advance is deferred until the locked tenure ends.
            state_d = ARB_LOCKED;
            owner_d = win_idx;
            burst_d = BURST_W'(1);
          end else begin
            ptr_d = inc_wrap(win_idx);
          end
        end
      end
      ARB_LOCKED: begin
        if (!iReq[owner_q] || !iLock[owner_q]) begin
          // Released by drop; a transfer with iReq but no iLock still completes.
          state_d = ARB_IDLE;
          ptr_d   = inc_wrap(owner_q);
          burst_d = '0;
        end else if (({1'b0, burst_q} + 9'd1) == 9'(MAX_BURST)) begin
          state_d = ARB_IDLE;
          ptr_d   = inc_wrap(owner_q);
          burst_d = '0;
        end else begin
          burst_d = burst_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: 4-requester instance (MAX_BURST=4) with a RAM model,
// plus a 3-requester instance for non-power-of-two pointer wrap.
// Inputs driven 1 time unit after posedge, outputs sampled 2 units after posedge.
module tb_ram_port_arbiter;

  logic        Clock;
  logic        Reset;

  // 4-requester instance
  logic [3:0]  req, wr, lk;
  logic [63:0] addr;
  logic [31:0] wdat;
  logic [3:0]  gnt, rdv;
  logic [7:0]  rdd, din, ram_q;
  logic        we;
  logic [15:0] raddr, waddr;

  // 3-requester instance
  logic [2:0]  req3;
  logic [47:0] addr3;
  logic [2:0]  gnt3, rdv3;
  logic [7:0]  rdd3, din3;
  logic        we3;
  logic [15:0] raddr3, waddr3;

  logic [7:0]  mem [0:65535];

  int n_checks = 0;
  int n_errors = 0;

  ram_port_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(16), .DATA_WIDTH(8), .MAX_BURST(4)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .iReq(req), .iWrite(wr), .iLock(lk), .iAddr(addr), .iWData(wdat),
    .oGrant(gnt), .oRdValid(rdv), .oRdData(rdd),
    .oRamWriteEnable(we), .oRamReadAddress(raddr), .oRamWriteAddress(waddr),
    .oRamDataIn(din), .iRamDataOut(ram_q)
  );

  ram_port_arbiter #(
    .NUM_REQ(3), .ADDR_WIDTH(16), .DATA_WIDTH(8), .MAX_BURST(16)
  ) dut3 (
    .Clock(Clock), .Reset(Reset),
    .iReq(req3), .iWrite(3'b000), .iLock(3'b000), .iAddr(addr3), .iWData(24'h0),
    .oGrant(gnt3), .oRdValid(rdv3), .oRdData(rdd3),
    .oRamWriteEnable(we3), .oRamReadAddress(raddr3), .oRamWriteAddress(waddr3),
    .oRamDataIn(din3), .iRamDataOut(8'h00)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // RAM model: registered read returning pre-write contents.
  always @(posedge Clock) begin
    if (we) mem[waddr] <= din;
    ram_q <= mem[raddr];
  end

  function automatic logic [7:0] preload(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  logic [3:0] exp_b [6];

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = preload(16'(a));
    Reset = 1'b1;
    req = '0; wr = '0; lk = '0; addr = '0; wdat = '0;
    req3 = '0; addr3 = {16'h0AB2, 16'h0AB1, 16'h0AB0};
    for (int k = 0; k < 4; k++) addr[k*16 +: 16] = 16'h0040 + 16'(k);

    // Reset: requests present but nothing granted
    cyc();
    req = 4'b1111;
    #1;
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_we", 32'(we), 32'h0);
    cyc();
    Reset = 1'b0;
    req = 4'b0000;
    #1;
    check_eq("rst_rdv", 32'(rdv), 32'h0);

    // All four read: grants rotate 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++) begin
      cyc();
      req = 4'b1111;
      #1;
      check_eq("rr_gnt", 32'(gnt), 32'(4'b0001 << (i % 4)));
      check_eq("rr_raddr", 32'(raddr), 32'(16'h0040 + 16'(i % 4)));
      if (i > 0) begin
        check_eq("rr_rdv", 32'(rdv), 32'(4'b0001 << ((i - 1) % 4)));
        check_eq("rr_rdd", 32'(rdd), 32'(preload(16'h0040 + 16'((i - 1) % 4))));
      end
    end
    cyc();
    req = 4'b0000;
    #1;
    check_eq("rr_last_rdv", 32'(rdv), 32'h8);
    check_eq("rr_last_rdd", 32'(rdd), 32'(preload(16'h0043)));
    check_eq("idle_gnt", 32'(gnt), 32'h0);

    // Requester 2 writes 0xA5 to 0x0010, requester 0 reads it back
    cyc();
    req = 4'b0100; wr = 4'b0100;
    addr[2*16 +: 16] = 16'h0010; wdat[2*8 +: 8] = 8'hA5;
    #1;
    check_eq("wr_gnt", 32'(gnt), 32'h4);
    check_eq("wr_we", 32'(we), 32'h1);
    check_eq("wr_waddr", 32'(waddr), 32'h0010);
    check_eq("wr_din", 32'(din), 32'hA5);
    cyc();
    req = 4'b0001; wr = 4'b0000;
    addr[0 +: 16] = 16'h0010;
    #1;
    check_eq("rd_gnt", 32'(gnt), 32'h1);
    check_eq("rd_we", 32'(we), 32'h0);
    check_eq("wr_no_rdv", 32'(rdv), 32'h0);
    cyc();
    req = 4'b0000;
    #1;
    check_eq("rd_rdv", 32'(rdv), 32'h1);
    check_eq("rd_rdd", 32'(rdd), 32'hA5);

    // Locked burst by requester 1 with 0 and 3 competing (pointer is at 1)
    exp_b = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0001};
    for (int i = 0; i < 6; i++) begin
      cyc();
      req = 4'b1011; lk = 4'b0010;
      #1;
      check_eq("burst_gnt", 32'(gnt), 32'(exp_b[i]));
    end
    cyc();
    req = 4'b0000; lk = 4'b0000;
    #1;
    check_eq("burst_end_gnt", 32'(gnt), 32'h0);

    // Requester 3 locks, drops after 2 transfers; next grant wraps to 0
    cyc();
    req = 4'b1000; lk = 4'b1000;
    #1;
    check_eq("lk3_gnt1", 32'(gnt), 32'h8);
    cyc();
    req = 4'b1001; lk = 4'b1000;
    #1;
    check_eq("lk3_gnt2", 32'(gnt), 32'h8);
    cyc();
    req = 4'b0001; lk = 4'b0000;
    #1;
    check_eq("lk3_drop_gnt", 32'(gnt), 32'h0);
    cyc();
    req = 4'b0011;
    #1;
    check_eq("lk3_after_gnt", 32'(gnt), 32'h1);
    cyc();
    req = 4'b0000;
    #1;

    // Reset right after an accepted read kills its oRdValid
    cyc();
    req = 4'b0100;
    #1;
    check_eq("kill_rd_gnt", 32'(gnt), 32'h4);
    cyc();
    Reset = 1'b1;
    #1;
    check_eq("kill_rst_gnt", 32'(gnt), 32'h0);
    check_eq("kill_rst_we", 32'(we), 32'h0);
    check_eq("kill_rst_rdv", 32'(rdv), 32'h0);
    cyc();
    Reset = 1'b0;
    req = 4'b1111;
    #1;
    check_eq("kill_post_rdv", 32'(rdv), 32'h0);
    check_eq("kill_post_gnt", 32'(gnt), 32'h1);
    cyc();
    req = 4'b0000;
    #1;
    check_eq("kill_post_rdv2", 32'(rdv), 32'h1);

    // NUM_REQ=3: single requester 2 every cycle, pointer wraps to 0
    for (int i = 0; i < 5; i++) begin
      cyc();
      req3 = 3'b100;
      #1;
      check_eq("n3_gnt", 32'(gnt3), 32'h4);
      check_eq("n3_we", 32'(we3), 32'h0);
      if (i > 0) check_eq("n3_rdv", 32'(rdv3), 32'h4);
    end
    cyc();
    req3 = 3'b000;
    #1;
    check_eq("n3_idle_gnt", 32'(gnt3), 32'h0);
    check_eq("n3_idle_rdv", 32'(rdv3), 32'h4);
    check_eq("n3_ptr_raddr", 32'(raddr3), 32'h0AB0);
    check_eq("n3_ptr_waddr", 32'(waddr3), 32'h0AB0);
    cyc();
    req3 = 3'b011;
    #1;
    check_eq("n3_wrap_gnt", 32'(gnt3), 32'h1);
    check_eq("n3_wrap_rdd", 32'(rdd3), 32'h0);
    check_eq("n3_wrap_din", 32'(din3), 32'h0);
    cyc();
    req3 = 3'b000;
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
